// File: rtl/uart_rx_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg_pkg
//  Description : Shared UART definitions: FSM state encodings, parity mode
//                encodings, default oversampling ratio, parity helper.
//                Also used by the transmitter successor.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_rx_cfg_pkg;

    // Receiver FSM state encodings
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_start   = 3'd1;
    localparam logic [2:0] c_st_data    = 3'd2;
    localparam logic [2:0] c_st_par     = 3'd3;
    localparam logic [2:0] c_st_stop    = 3'd4;
    localparam logic [2:0] c_st_wait_hi = 3'd5;

    // Parity mode encodings
    localparam logic [1:0] c_par_none = 2'd0;
    localparam logic [1:0] c_par_even = 2'd1;
    localparam logic [1:0] c_par_odd  = 2'd2;

    // Default number of br_tick pulses per bit period
    localparam int c_default_oversample = 16;

    // XOR of payload and received parity bit is 0 for a good even-parity
    // frame and 1 for a good odd-parity frame.
    function automatic logic parity_error(input logic xor_all, input logic [1:0] mode);
        return (mode == c_par_odd) ? ~xor_all : xor_all;
    endfunction

endpackage : uart_rx_cfg_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchroniser for a single asynchronous input, with
//                a configurable reset value (idle level of the line).
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Parametrised oversampling UART receiver with input
//                synchroniser, start-bit glitch rejection, optional parity
//                and one or two stop bits with framing error detection.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = c_default_oversample,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 br_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = $clog2(DATA_BITS + 1);

    localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);
    localparam logic [1:0]          c_par_mode  = 2'(PARITY);

    logic                 w_rx_s;
    logic [2:0]           r_state,      w_state_next;
    logic [c_tick_w-1:0]  r_tick_cnt,   w_tick_next;
    logic [c_bit_w-1:0]   r_bit_cnt,    w_bit_next;
    logic [DATA_BITS-1:0] r_sh,         w_sh_next;
    logic                 r_p_err,      w_p_err_next;
    logic                 r_f_err,      w_f_err_next;
    logic [DATA_BITS-1:0] r_rx_data,    w_rx_data_next;
    logic                 r_rx_done,    w_rx_done_next;
    logic                 r_parity_err, w_parity_err_next;
    logic                 r_frame_err,  w_frame_err_next;
    logic                 w_busy;
    logic                 w_stop_ferr;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // Framing error accumulated including the stop sample being taken now
    assign w_stop_ferr = r_f_err | ~w_rx_s;

    // State, counters, shift register and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_sh         <= '0;
            r_p_err      <= 1'b0;
            r_f_err      <= 1'b0;
            r_rx_data    <= '0;
            r_rx_done    <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_tick_cnt   <= w_tick_next;
            r_bit_cnt    <= w_bit_next;
            r_sh         <= w_sh_next;
            r_p_err      <= w_p_err_next;
            r_f_err      <= w_f_err_next;
            r_rx_data    <= w_rx_data_next;
            r_rx_done    <= w_rx_done_next;
            r_parity_err <= w_parity_err_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    // Next-state logic: sample on br_tick at bit centres, counters clear on every transition
    always_comb begin
        w_state_next      = r_state;
        w_tick_next       = r_tick_cnt;
        w_bit_next        = r_bit_cnt;
        w_sh_next         = r_sh;
        w_p_err_next      = r_p_err;
        w_f_err_next      = r_f_err;
        w_rx_data_next    = r_rx_data;
        w_rx_done_next    = 1'b0;
        w_parity_err_next = r_parity_err;
        w_frame_err_next  = r_frame_err;

        case (r_state)
            c_st_idle: begin
                w_tick_next = '0;
                if (!w_rx_s) begin
                    w_state_next = c_st_start;
                    w_bit_next   = '0;
                    w_p_err_next = 1'b0;
                    w_f_err_next = 1'b0;
                end
            end
            c_st_start: begin
                if (br_tick) begin
                    if (r_tick_cnt == c_tick_half) begin
                        // Line back high at the start-bit centre is a glitch
                        w_state_next = w_rx_s ? c_st_idle : c_st_data;
                        w_tick_next  = '0;
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            c_st_data: begin
                if (br_tick) begin
                    if (r_tick_cnt == c_tick_last) begin
                        w_sh_next   = {w_rx_s, r_sh[DATA_BITS-1:1]};
                        w_bit_next  = r_bit_cnt + 1'b1;
                        w_tick_next = '0;
                        if (r_bit_cnt == c_bit_last) begin
                            w_state_next = (c_par_mode != c_par_none) ? c_st_par : c_st_stop;
                            w_bit_next   = '0;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            c_st_par: begin
                if (br_tick) begin
                    if (r_tick_cnt == c_tick_last) begin
                        w_p_err_next = parity_error(^r_sh ^ w_rx_s, c_par_mode);
                        w_state_next = c_st_stop;
                        w_tick_next  = '0;
                        w_bit_next   = '0;
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            c_st_stop: begin
                if (br_tick) begin
                    if (r_tick_cnt == c_tick_last) begin
                        w_f_err_next = w_stop_ferr;
                        w_tick_next  = '0;
                        if (r_bit_cnt == c_stop_last) begin
                            // Frame complete: publish payload and flags, leave mid stop bit
                            w_rx_data_next    = r_sh;
                            w_parity_err_next = r_p_err;
                            w_frame_err_next  = w_stop_ferr;
                            w_rx_done_next    = 1'b1;
                            w_bit_next        = '0;
                            w_state_next      = w_stop_ferr ? c_st_wait_hi : c_st_idle;
                        end else begin
                            w_bit_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            c_st_wait_hi: begin
                // Hold off until a break releases so it reports only one frame
                w_tick_next = '0;
                if (w_rx_s) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_tick_next  = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    // Output decode: busy in every state except IDLE
    always_comb begin
        w_busy = (r_state != c_st_idle);
    end

    assign rx_data    = r_rx_data;
    assign rx_done    = r_rx_done;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = w_busy;

endmodule : uart_rx_cfg
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Directed self-checking bench for uart_rx_cfg: 8N1, 8E1 and
//                7O2 instances, glitch, break, and mid-frame reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int c_bit_clks = 64;   // 16 ticks x 4 clk

    logic       clk;
    logic       reset;
    logic       br_tick;
    logic [1:0] r_div;
    logic       rx_line;
    int         sel;

    logic       rx_a, rx_b, rx_c;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       done_a, done_b, done_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       busy_a, busy_b, busy_c;

    int         done_cnt_a, done_cnt_b, done_cnt_c;
    int         n_cmp, n_err;
    int         base;

    assign rx_a = (sel == 0) ? rx_line : 1'b1;
    assign rx_b = (sel == 1) ? rx_line : 1'b1;
    assign rx_c = (sel == 2) ? rx_line : 1'b1;

    uart_rx_cfg u_8n1 (
        .clk (clk), .reset (reset), .rx (rx_a), .br_tick (br_tick),
        .rx_data (data_a), .rx_done (done_a), .parity_err (perr_a),
        .frame_err (ferr_a), .busy (busy_a)
    );

    uart_rx_cfg #(.PARITY (1)) u_8e1 (
        .clk (clk), .reset (reset), .rx (rx_b), .br_tick (br_tick),
        .rx_data (data_b), .rx_done (done_b), .parity_err (perr_b),
        .frame_err (ferr_b), .busy (busy_b)
    );

    uart_rx_cfg #(.DATA_BITS (7), .PARITY (2), .STOP_BITS (2)) u_7o2 (
        .clk (clk), .reset (reset), .rx (rx_c), .br_tick (br_tick),
        .rx_data (data_c), .rx_done (done_c), .parity_err (perr_c),
        .frame_err (ferr_c), .busy (busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // br_tick: one clk pulse every 4 clk
    always @(posedge clk) begin
        r_div   <= r_div + 2'd1;
        br_tick <= (r_div == 2'd3);
    end

    // Count clocks with rx_done high; one frame must add exactly one
    always @(posedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (done_c) done_cnt_c <= done_cnt_c + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        repeat (c_bit_clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] data, input int ndata,
                              input bit par_en, input logic par_bit,
                              input logic [1:0] stops, input int nstop);
        send_bit(1'b0);
        for (int i = 0; i < ndata; i++) send_bit(data[i]);
        if (par_en) send_bit(par_bit);
        for (int i = 0; i < nstop; i++) send_bit(stops[i]);
    endtask

    task automatic idle(input int nbits);
        rx_line = 1'b1;
        repeat (nbits * c_bit_clks) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        done_cnt_a = 0; done_cnt_b = 0; done_cnt_c = 0;
        r_div = 2'd0; br_tick = 1'b0;
        rx_line = 1'b1; sel = 0;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_data", {24'd0, data_a}, 32'd0);
        check_eq("rst_done", {31'd0, done_a}, 32'd0);
        check_eq("rst_perr", {31'd0, perr_a}, 32'd0);
        check_eq("rst_ferr", {31'd0, ferr_a}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        reset = 1'b0;
        idle(1);

        // 1: 8N1 0xA5
        base = done_cnt_a;
        send_bit(1'b0);
        check_eq("t1_busy_mid", {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0);
        send_bit(1'b1);
        idle(2);
        check_eq("t1_data", {24'd0, data_a}, 32'hA5);
        check_eq("t1_done_cnt", done_cnt_a - base, 32'd1);
        check_eq("t1_perr", {31'd0, perr_a}, 32'd0);
        check_eq("t1_ferr", {31'd0, ferr_a}, 32'd0);
        check_eq("t1_busy_end", {31'd0, busy_a}, 32'd0);

        // 2: 8E1, 0x07 with good then bad parity
        sel = 1;
        base = done_cnt_b;
        send_frame(9'h007, 8, 1'b1, 1'b1, 2'b11, 1);
        idle(2);
        check_eq("t2_data_ok", {24'd0, data_b}, 32'h07);
        check_eq("t2_perr_ok", {31'd0, perr_b}, 32'd0);
        send_frame(9'h007, 8, 1'b1, 1'b0, 2'b11, 1);
        idle(2);
        check_eq("t2_data_bad", {24'd0, data_b}, 32'h07);
        check_eq("t2_perr_bad", {31'd0, perr_b}, 32'd1);
        check_eq("t2_done_cnt", done_cnt_b - base, 32'd2);

        // 3: start glitch of 4 ticks, then 0x3C
        sel = 0;
        base = done_cnt_a;
        rx_line = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        idle(2);
        check_eq("t3_glitch_done", done_cnt_a - base, 32'd0);
        check_eq("t3_glitch_busy", {31'd0, busy_a}, 32'd0);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 2'b11, 1);
        idle(2);
        check_eq("t3_data", {24'd0, data_a}, 32'h3C);
        check_eq("t3_done_cnt", done_cnt_a - base, 32'd1);
        check_eq("t3_ferr", {31'd0, ferr_a}, 32'd0);

        // 4: break (0x00 with stop 0, low 3 more bits), then 0x81
        base = done_cnt_a;
        send_frame(9'h000, 8, 1'b0, 1'b0, 2'b00, 1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        check_eq("t4_break_done", done_cnt_a - base, 32'd1);
        check_eq("t4_break_ferr", {31'd0, ferr_a}, 32'd1);
        check_eq("t4_break_data", {24'd0, data_a}, 32'h00);
        check_eq("t4_break_busy", {31'd0, busy_a}, 32'd1);
        idle(1);
        check_eq("t4_release_busy", {31'd0, busy_a}, 32'd0);
        send_frame(9'h081, 8, 1'b0, 1'b0, 2'b11, 1);
        idle(2);
        check_eq("t4_data", {24'd0, data_a}, 32'h81);
        check_eq("t4_ferr", {31'd0, ferr_a}, 32'd0);
        check_eq("t4_done_cnt", done_cnt_a - base, 32'd2);

        // 5: 7O2, 0x55 with odd parity bit 1
        sel = 2;
        base = done_cnt_c;
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(((8'h55 >> i) & 8'h01) != 0);
        send_bit(1'b1);
        send_bit(1'b1);
        check_eq("t5_no_done_1st_stop", done_cnt_c - base, 32'd0);
        send_bit(1'b1);
        idle(1);
        check_eq("t5_done_cnt", done_cnt_c - base, 32'd1);
        check_eq("t5_data", {25'd0, data_c}, 32'h55);
        check_eq("t5_perr", {31'd0, perr_c}, 32'd0);
        check_eq("t5_ferr", {31'd0, ferr_c}, 32'd0);
        send_frame(9'h055, 7, 1'b1, 1'b1, 2'b01, 2);
        idle(2);
        check_eq("t5_ferr2", {31'd0, ferr_c}, 32'd1);
        check_eq("t5_done_cnt2", done_cnt_c - base, 32'd2);

        // 6: reset during data bit 4, then 0xC3
        sel = 0;
        base = done_cnt_a;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'hC3 >> i) & 8'h01) != 0);
        rx_line = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        check_eq("t6_busy_pre", {31'd0, busy_a}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_data", {24'd0, data_a}, 32'd0);
        check_eq("t6_rst_done", {31'd0, done_a}, 32'd0);
        check_eq("t6_rst_perr", {31'd0, perr_a}, 32'd0);
        check_eq("t6_rst_ferr", {31'd0, ferr_a}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, busy_a}, 32'd0);
        rx_line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        check_eq("t6_no_done", done_cnt_a - base, 32'd0);
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 2'b11, 1);
        idle(2);
        check_eq("t6_data", {24'd0, data_a}, 32'hC3);
        check_eq("t6_done_cnt", done_cnt_a - base, 32'd1);
        check_eq("t6_ferr", {31'd0, ferr_a}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_rx_cfg
`default_nettype wire
